// File: rtl/mac_tile_scheduler.sv
// mac_tile_scheduler: steps one tile through operand fetch, MAC issue, partial-sum latch and PPU drain
module mac_tile_scheduler #(
    parameter int CALC_COUNT = 4,
    parameter int K_W        = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [1:0]     cfg_mode,
    input  logic [K_W-1:0] cfg_k_steps,
    output logic           err_cfg,
    output logic           buf_req,
    output logic [K_W-1:0] buf_addr,
    input  logic           buf_ack,
    output logic           mac_valid,
    output logic           mac_int8,
    output logic           mac_int4,
    output logic           mac_vsq,
    output logic           acc_start,
    output logic           acc_mac_done,
    output logic           acc_ppu,
    input  logic           acc_done,
    output logic           busy,
    output logic           tile_done
);
    localparam int CW = $clog2(CALC_COUNT + 1);
    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, DRAIN, DONE} state_t;
    state_t state, state_n;
    logic [K_W-1:0] k_idx, k_idx_n, k_num, k_num_n;
    logic [1:0] mode, mode_n;
    logic [CW-1:0] cnt, cnt_n;
    logic cfg_ok, last_cnt, pre_cnt, last_k;
    assign cfg_ok   = cfg_mode != 2'b11 && cfg_k_steps != '0;
    assign last_cnt = cnt == CW'(CALC_COUNT - 1);
    // outputs are registered, so the pulses due at cnt==CALC_COUNT-1 are launched one count early
    assign pre_cnt  = cnt == CW'(CALC_COUNT - 2);
    assign last_k   = k_idx == k_num - K_W'(1);
    always_comb begin
        state_n = state;
        k_idx_n = k_idx;
        k_num_n = k_num;
        mode_n  = mode;
        cnt_n   = cnt;
        unique case (state)
            IDLE: if (cfg_valid && cfg_ok) begin
                state_n = FETCH;
                k_idx_n = '0;
                k_num_n = cfg_k_steps;
                mode_n  = cfg_mode;
            end
            FETCH: state_n = buf_ack ? ISSUE : FETCH;
            ISSUE: begin
                state_n = WAIT;
                cnt_n   = '0;
            end
            WAIT: begin
                cnt_n = cnt + CW'(1);
                if (last_cnt) begin
                    state_n = last_k ? DRAIN : FETCH;
                    k_idx_n = last_k ? k_idx : k_idx + K_W'(1);
                end
            end
            DRAIN: state_n = acc_done ? DONE : DRAIN;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            k_idx        <= '0;
            k_num        <= '0;
            mode         <= '0;
            cnt          <= '0;
            cfg_ready    <= 1'b1;
            err_cfg      <= 1'b0;
            buf_req      <= 1'b0;
            buf_addr     <= '0;
            mac_valid    <= 1'b0;
            mac_int8     <= 1'b0;
            mac_int4     <= 1'b0;
            mac_vsq      <= 1'b0;
            acc_start    <= 1'b0;
            acc_mac_done <= 1'b0;
            acc_ppu      <= 1'b0;
            busy         <= 1'b0;
            tile_done    <= 1'b0;
        end else begin
            state        <= state_n;
            k_idx        <= k_idx_n;
            k_num        <= k_num_n;
            mode         <= mode_n;
            cnt          <= cnt_n;
            cfg_ready    <= state_n == IDLE;
            err_cfg      <= state == IDLE && cfg_valid && !cfg_ok;
            buf_req      <= state_n == FETCH;
            buf_addr     <= k_idx_n;
            mac_valid    <= state_n == ISSUE;
            mac_int8     <= state_n != IDLE && mode_n == 2'd0;
            mac_int4     <= state_n != IDLE && mode_n == 2'd1;
            mac_vsq      <= state_n != IDLE && mode_n == 2'd2;
            acc_start    <= state == IDLE && state_n == FETCH;
            acc_mac_done <= state == WAIT && pre_cnt;
            acc_ppu      <= state == WAIT && pre_cnt && last_k;
            busy         <= state_n != IDLE;
            tile_done    <= state_n == DONE;
        end
    end
endmodule
